// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table scan checker.
// Contents:
//   tt_state_t  - controller states (IDLE, RUN, DONE)
//   NUM_VEC     - number of input vectors in a 4-input truth table
//   VEC_W       - width of the vector index
//   ERR_W       - width of the mismatch counter (holds 0..16 without wrapping)
//   timer_width - width needed to hold a settle count, never less than 1 bit
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tt_state_t;

    localparam int NUM_VEC = 16;
    localparam int VEC_W   = 4;
    localparam int ERR_W   = 5;

    function automatic int timer_width(input int settle);
        if (settle <= 1) begin
            return 1;
        end else begin
            return $clog2(settle + 1);
        end
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Settle-time down counter for the scan checker.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high; clears the count
//   load  - load the count with SETTLE (wins over dec)
//   dec   - decrement the count; it holds at zero
//   zero  - count is zero, i.e. the current vector has settled
module tt_settle_timer
    import tt_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int CNT_W = timer_width(SETTLE);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count_r;

    // Count register: load takes priority, decrement stops at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= CNT_ZERO;
        end else if (load) begin
            count_r <= LOAD_VAL;
        end else if (dec && (count_r != CNT_ZERO)) begin
            count_r <= count_r - CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == CNT_ZERO);

endmodule

// File: rtl/tt_scan_checker.sv
// Self-running exhaustive checker for a 4-input combinational block.
// On start it steps the vector {g,t,u,e} from 0000 to 1111, holds each vector
// for SETTLE+1 cycles, samples y on the last of those cycles and compares it
// with EXPECTED[vector].
// Ports:
//   clk, reset       - clock and synchronous active-high reset
//   start            - run request, only looked at in IDLE
//   g, t, u, e       - stimulus vector bits 3..0 (0000 outside RUN)
//   y                - response of the block under test
//   busy             - high while vectors are being applied
//   done             - one-cycle pulse after the last vector
//   pass             - last run had no mismatches
//   err_count        - number of mismatching vectors (0..16)
//   first_err        - index of the first mismatching vector
//   first_err_valid  - first_err holds a real index
//   captured         - observed y, bit i is the sample for vector i
module tt_scan_checker
    import tt_pkg::*;
#(
    parameter logic [15:0] EXPECTED = 16'h0000,
    parameter int          SETTLE   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               g,
    output logic               t,
    output logic               u,
    output logic               e,
    input  logic               y,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic [VEC_W-1:0]   first_err,
    output logic               first_err_valid,
    output logic [NUM_VEC-1:0] captured
);

    tt_state_t          state_r;
    tt_state_t          state_next_s;
    logic [VEC_W-1:0]   vec_r;
    logic [ERR_W-1:0]   err_count_r;
    logic [ERR_W-1:0]   err_next_s;
    logic [VEC_W-1:0]   first_err_r;
    logic               first_err_valid_r;
    logic               pass_r;
    logic               busy_r;
    logic               done_r;
    logic [NUM_VEC-1:0] captured_r;
    logic [NUM_VEC-1:0] expected_s;
    logic               timer_zero_s;
    logic               timer_load_s;
    logic               timer_dec_s;
    logic               sample_s;
    logic               last_vec_s;
    logic               mismatch_s;
    logic               busy_next_s;
    logic               done_next_s;

    assign expected_s = EXPECTED;
    assign sample_s   = (state_r == RUN) && timer_zero_s;
    assign last_vec_s = (vec_r == VEC_W'(NUM_VEC - 1));
    assign mismatch_s = sample_s && (y != expected_s[vec_r]);
    assign err_next_s = mismatch_s ? (err_count_r + ERR_W'(1)) : err_count_r;

    tt_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (timer_load_s),
        .dec   (timer_dec_s),
        .zero  (timer_zero_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: a run ends on the sample of the last vector.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (sample_s && last_vec_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Control outputs; busy/done are decoded from the next state so that
    // their registered copies line up with the state register.
    always_comb begin
        timer_load_s = ((state_r == IDLE) && start) || (sample_s && !last_vec_s);
        timer_dec_s  = (state_r == RUN) && !timer_zero_s;
        busy_next_s  = (state_next_s == RUN);
        done_next_s  = (state_next_s == DONE);
    end

    // Vector counter and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            vec_r             <= 4'd0;
            err_count_r       <= 5'd0;
            first_err_r       <= 4'd0;
            first_err_valid_r <= 1'b0;
            pass_r            <= 1'b0;
            captured_r        <= 16'h0000;
            busy_r            <= 1'b0;
            done_r            <= 1'b0;
        end else begin
            busy_r <= busy_next_s;
            done_r <= done_next_s;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        vec_r             <= 4'd0;
                        err_count_r       <= 5'd0;
                        first_err_r       <= 4'd0;
                        first_err_valid_r <= 1'b0;
                        pass_r            <= 1'b0;
                        captured_r        <= 16'h0000;
                    end else begin
                        vec_r <= 4'd0;
                    end
                end
                RUN: begin
                    if (sample_s) begin
                        captured_r[vec_r] <= y;
                        err_count_r       <= err_next_s;
                        if (mismatch_s && !first_err_valid_r) begin
                            first_err_r       <= vec_r;
                            first_err_valid_r <= 1'b1;
                        end else begin
                            first_err_r       <= first_err_r;
                            first_err_valid_r <= first_err_valid_r;
                        end
                        // Clearing the vector on the last sample keeps g,t,u,e
                        // at 0000 during DONE; pass is set early so it is
                        // already valid while done is high.
                        if (last_vec_s) begin
                            vec_r  <= 4'd0;
                            pass_r <= (err_next_s == 5'd0);
                        end else begin
                            vec_r <= vec_r + 4'd1;
                        end
                    end else begin
                        vec_r <= vec_r;
                    end
                end
                DONE: begin
                    vec_r  <= 4'd0;
                    pass_r <= (err_count_r == 5'd0);
                end
                default: begin
                    vec_r <= 4'd0;
                end
            endcase
        end
    end

    assign g               = vec_r[3];
    assign t               = vec_r[2];
    assign u               = vec_r[1];
    assign e               = vec_r[0];
    assign busy            = busy_r;
    assign done            = done_r;
    assign pass            = pass_r;
    assign err_count       = err_count_r;
    assign first_err       = first_err_r;
    assign first_err_valid = first_err_valid_r;
    assign captured        = captured_r;

endmodule

// File: doc/tt_scan_checker.md
# tt_scan_checker

Self-running truth-table checker for 4-input combinational lab blocks. On `start` it drives every input vector 0000→1111 onto `g,t,u,e`, waits a programmable settle time, and samples the block's `y`. Each sample is compared against a parameterised expected truth table, with mismatch statistics reported. It takes over the role of a hand-written stimulus bench: it is the receiving and checking end of the same exhaustive-vector interface, and can run on the board as well as in simulation.

## Interface
- `EXPECTED`, 16'h0000, expected `y`; bit i is the result for vector i = {g,t,u,e}
- `SETTLE`, 2, extra cycles each vector is held before sampling; legal range 0..15
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-high; fixed
- `start`  in  1  run request, sampled only in IDLE
- `g`, `t`, `u`, `e`  out  1 each  stimulus vector bits 3..0
- `y`  in  1  response of the block under test
- `busy`  out  1  high while vectors are being applied
- `done`  out  1  one-cycle pulse at end of run
- `pass`  out  1  1 when the last run had zero mismatches
- `err_count`  out  5  mismatch count, 0..16
- `first_err`  out  4  index of first mismatching vector
- `first_err_valid`  out  1  `first_err` holds a real index
- `captured`  out  16  observed `y`, bit i is the sample for vector i

## Operation
- Three states: IDLE, RUN, DONE.
- **IDLE:**
  - `start`=1 → RUN.
  - On the same edge: vector←0, settle counter←SETTLE, and `err_count`, `captured`, `first_err`, `first_err_valid`, `pass` all cleared.
- **RUN:**
  - Counter ≠ 0: decrement.
  - Counter = 0: captured[vec]←y.
  - If y ≠ EXPECTED[vec]: err_count+1. If `first_err_valid`=0, also set first_err←vec and first_err_valid←1.
  - Then, if vec = 15 → DONE. Otherwise vec+1 and counter←SETTLE.
- **DONE:**
  - `done`=1 and pass←(err_count = 0).
  - vec←0.
  - Next cycle → IDLE.
- Outputs `g,t,u,e` are the registered vector bits 3..0. They read 0000 outside RUN.
- `busy` = (state = RUN).
- `start` is ignored in RUN and DONE. It is not queued.
- Results hold unchanged from DONE until the next accepted `start`.
- `err_count` is 5 bits so that 16 mismatches is representable and never wraps.
- The vector counter is 4 bits. The vec=15 check ends the run, so it never wraps.

## Timing
- Reset values: state IDLE, vector 0000, all outputs 0, `captured`=16'h0000.
- `reset` takes priority over every other input. Reset mid-run aborts on the next edge to the reset values, with no `done` pulse.
- Each vector is driven for SETTLE+1 RUN cycles. `y` is sampled at the end of the last of these cycles.
- The combinational path through the block under test therefore has at least SETTLE+1 full cycles to settle.
- `start` accepted at edge k:
  - `busy` is high from k to k+16·(SETTLE+1).
  - `done` is high for the single cycle that follows.
  - With SETTLE=2 this gives 48 RUN cycles and `done` in cycle 49.
- `pass`, `err_count`, `first_err` and `captured` are valid no later than the cycle `done` is high.
- `start` held high continuously starts a new run on the first IDLE cycle after DONE.

## Structure
- Package `tt_pkg` holds:
  - typedef `tt_state_t` {IDLE, RUN, DONE}
  - `NUM_VEC`=16
  - `VEC_W`=4
  - `ERR_W`=5
- One sub-module is natural: `tt_settle_timer` (load/decrement/zero-flag counter with width derived from SETTLE, minimum 1 bit).
- Everything else is a single FSM plus datapath in `tt_scan_checker`.

## Test plan
- **Reset values:** reset held 3 cycles → all outputs 0, vector 0000, `captured`=16'h0000, `busy`=0.
- **Correct block:** model y=(g|t)&(u|e), EXPECTED=16'hEEE0, SETTLE=2, one-cycle `start` → each vector 0..15 held exactly 3 cycles, `done` pulse in cycle 49 → pass=1, err_count=0, captured=16'hEEE0, first_err_valid=0.
- **Stuck-at-0 block:** y tied 0, EXPECTED=16'hEEE0 → err_count=9, first_err=5, first_err_valid=1, pass=0, captured=16'h0000.
- **Ignored start, then rerun:** `start` pulsed during RUN and during DONE → ignored, same cycle count. A new `start` in IDLE clears results, and a rerun with the correct model gives pass=1.
- **Reset mid-run:** reset asserted while vector=0111 → next edge all outputs at reset values, no `done`. A subsequent `start` begins at 0000.
- **SETTLE=0:** correct model → one cycle per vector, `done` in cycle 17, pass=1.
